// File: rtl/fifo_rd_drainer_pkg.sv
// Shared types and constants for the async-FIFO read-side drainer.
package fifo_rd_drainer_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned OCC_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_rd_drainer_if.sv
// FIFO read port plus the valid/ready output stream of the drainer.
interface fifo_rd_drainer_if
    import fifo_rd_drainer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              rd_en;
    logic              rd_empty;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;

    modport master (
        output rd_en,
        input  rd_empty, rd_data, rd_valid,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  rd_en,
        output rd_empty, rd_data, rd_valid,
        input  m_valid, m_data, m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer with a registered head; absorbs the FIFO read latency.
module fifo_skid_buf
    import fifo_rd_drainer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    input  logic              ready,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [OCC_W-1:0]  occ_q;
    logic              pop;

    assign valid = (occ_q != '0);
    assign data  = head_q;
    assign occ   = occ_q;
    assign pop   = valid & ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            case (occ_q)
                2'd0: begin
                    if (push) begin
                        head_q <= push_data;
                        occ_q  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_q <= push_data;
                    end else if (push) begin
                        tail_q <= push_data;
                        occ_q  <= 2'd2;
                    end else if (pop) begin
                        occ_q  <= 2'd0;
                    end
                end
                default: begin
                    // Full: tail shifts into the head on every accepted beat.
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            occ_q  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    // The rd_en gating upstream guarantees a full buffer is never pushed without a pop.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && (occ_q == 2'd2) && !pop));
        end
    end

endmodule

// File: rtl/fifo_rd_drainer.sv
// Read-side master for the async FIFO: pops while non-empty and re-emits words on a stream.
module fifo_rd_drainer
    import fifo_rd_drainer_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BURST_LEN = 0,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               rd_clk,
    input  logic               rst_rd,
    input  logic               en,
    fifo_rd_drainer_if.master  bus,
    output logic               busy,
    output logic [CNT_W-1:0]   words_out,
    output logic               err_unexp
);

    localparam int unsigned BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned LAST_BEAT = (BURST_LEN == 0) ? 0 : BURST_LEN - 1;

    drain_state_e      state_q;
    logic              inflight_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic              push;
    logic              drained;
    logic [2:0]        pending;

    assign pop     = bus.m_valid & bus.m_ready;
    assign push    = bus.rd_valid & inflight_q;
    assign drained = ~inflight_q & (occ == '0);

    // Words already owned by the buffer after this cycle's pop; keeps room for one more.
    assign pending   = 3'(occ) + 3'(inflight_q) - 3'(pop);
    assign bus.rd_en = (state_q == RUN) & en & ~bus.rd_empty & (pending < 3'd2);

    assign busy       = (state_q != IDLE);
    assign bus.m_last = bus.m_valid & (BURST_LEN != 0) & (beat_cnt_q == BEAT_W'(LAST_BEAT));

    fifo_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (rd_clk),
        .rst       (rst_rd),
        .push      (push),
        .push_data (bus.rd_data),
        .valid     (bus.m_valid),
        .data      (bus.m_data),
        .ready     (bus.m_ready),
        .occ       (occ)
    );

    always_ff @(posedge rd_clk) begin
        if (rst_rd) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            words_out  <= '0;
            err_unexp  <= 1'b0;
        end else begin
            inflight_q <= bus.rd_en;

            if (bus.rd_valid && !inflight_q) begin
                err_unexp <= 1'b1;
            end

            if (pop) begin
                words_out <= words_out + CNT_W'(1);
            end

            case (state_q)
                IDLE:    if (en)      state_q <= RUN;
                RUN:     if (!en)     state_q <= STOP;
                STOP:    if (drained) state_q <= IDLE;
                default:              state_q <= IDLE;
            endcase

            // No pop can coincide with IDLE entry, since the buffer is empty then.
            if ((state_q == STOP) && drained) begin
                beat_cnt_q <= '0;
            end else if (pop) begin
                if ((BURST_LEN == 0) || (beat_cnt_q == BEAT_W'(LAST_BEAT))) begin
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_drainer.sv
// Directed bench for fifo_rd_drainer driving a behavioural FIFO read port.
module tb_fifo_rd_drainer;
    import fifo_rd_drainer_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          rd_clk = 1'b0;
    logic          rst_rd = 1'b1;
    logic          en     = 1'b0;
    logic          inject = 1'b0;
    logic          busy, busy0, err, err0;
    logic [CW-1:0] words, words0;

    logic [DW-1:0] mem [16];
    logic [4:0]    wr_cnt = 5'd0;
    logic [4:0]    rd_ptr;

    int errors = 0;
    int checks = 0;

    fifo_rd_drainer_if #(.DATA_W(DW)) bus  ();
    fifo_rd_drainer_if #(.DATA_W(DW)) bus0 ();

    fifo_rd_drainer #(.DATA_W(DW), .BURST_LEN(4), .CNT_W(CW)) dut (
        .rd_clk    (rd_clk),
        .rst_rd    (rst_rd),
        .en        (en),
        .bus       (bus),
        .busy      (busy),
        .words_out (words),
        .err_unexp (err)
    );

    // Unframed twin fed with identical FIFO/stream inputs.
    fifo_rd_drainer #(.DATA_W(DW), .BURST_LEN(0), .CNT_W(CW)) dut0 (
        .rd_clk    (rd_clk),
        .rst_rd    (rst_rd),
        .en        (en),
        .bus       (bus0),
        .busy      (busy0),
        .words_out (words0),
        .err_unexp (err0)
    );

    assign bus0.rd_empty = bus.rd_empty;
    assign bus0.rd_data  = bus.rd_data;
    assign bus0.rd_valid = bus.rd_valid;
    assign bus0.m_ready  = bus.m_ready;

    initial forever #5 rd_clk = ~rd_clk;

    // FIFO read port: one-cycle rd_data latency, optional spurious rd_valid.
    always @(posedge rd_clk) begin
        if (rst_rd) begin
            rd_ptr       <= 5'd0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.rd_empty <= (wr_cnt == 5'd0);
        end else if (bus.rd_en && (rd_ptr != wr_cnt)) begin
            bus.rd_valid <= 1'b1;
            bus.rd_data  <= mem[rd_ptr[3:0]];
            rd_ptr       <= 5'(rd_ptr + 5'd1);
            bus.rd_empty <= (5'(rd_ptr + 5'd1) == wr_cnt);
        end else begin
            bus.rd_valid <= inject;
            bus.rd_data  <= inject ? 32'hBAD0_0BAD : '0;
            bus.rd_empty <= (rd_ptr == wr_cnt);
        end
    end

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < 16; i++) mem[i] = (i < n) ? DW'(base + DW'(i)) : '0;
        wr_cnt = 5'(n);
    endtask

    task automatic do_reset(input int n, input logic [DW-1:0] base);
        @(negedge rd_clk);
        rst_rd = 1'b1;
        en = 1'b0;
        inject = 1'b0;
        bus.m_ready = 1'b0;
        load(n, base);
        repeat (2) @(negedge rd_clk);
        rst_rd = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge rd_clk);
        rst_rd = 1'b1;
        en = 1'b1;
        bus.m_ready = 1'b1;
        load(4, 32'h01);
        for (int c = 0; c < 3; c++) begin
            @(negedge rd_clk); #1;
            checks++;
            if ({bus.rd_en, bus.m_valid, busy, err} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_flags cyc%0d: rd_en/m_valid/busy/err got %b expected 0000", c,
                         {bus.rd_en, bus.m_valid, busy, err});
            end
            checks++;
            if (words !== '0) begin
                errors++;
                $display("FAIL reset_words cyc%0d: got %0d expected 0", c, words);
            end
        end
        rst_rd = 1'b0;
        #1;
        checks++;
        if (bus.rd_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_rd_en: got %b expected 0", bus.rd_en);
        end
        @(negedge rd_clk); #1;
        checks++;
        if ({bus.rd_en, busy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_run_entry: rd_en/busy got %b expected 11", {bus.rd_en, busy});
        end
    endtask

    task automatic test_stream();
        logic exp_en, exp_v;
        logic [DW-1:0] exp_d;
        do_reset(8, 32'h10);
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge rd_clk); #1;
            exp_en = (k >= 1) && (k <= 8);
            exp_v  = (k >= 3) && (k <= 10);
            exp_d  = DW'(32'h10 + k - 3);
            checks++;
            if (bus.rd_en !== exp_en) begin
                errors++;
                $display("FAIL stream_rd_en k=%0d: got %b expected %b", k, bus.rd_en, exp_en);
            end
            checks++;
            if (bus.m_valid !== exp_v) begin
                errors++;
                $display("FAIL stream_m_valid k=%0d: got %b expected %b", k, bus.m_valid, exp_v);
            end
            if (exp_v) begin
                checks++;
                if ((bus.m_data !== exp_d) || (bus0.m_data !== exp_d)) begin
                    errors++;
                    $display("FAIL stream_m_data k=%0d: got %h/%h expected %h", k, bus.m_data,
                             bus0.m_data, exp_d);
                end
                checks++;
                if (bus0.m_last !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_nolast k=%0d: got %b expected 0", k, bus0.m_last);
                end
            end
        end
        checks++;
        if ((words !== CW'(8)) || (words0 !== CW'(8))) begin
            errors++;
            $display("FAIL stream_words_out: got %0d/%0d expected 8", words, words0);
        end
    endtask

    task automatic test_backpressure();
        int got = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic [2:0] pend;
        do_reset(6, 32'h30);
        en = 1'b1;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge rd_clk);
            bus.m_ready = (c % 2 == 0);
            #1;
            pend = 3'(dut.u_skid.occ_q) + 3'(dut.inflight_q) - 3'(bus.m_valid & bus.m_ready);
            checks++;
            if ((dut.u_skid.occ_q > 2'd2) || (bus.rd_en && (pend >= 3'd2)) ||
                (bus.rd_en && bus.rd_empty)) begin
                errors++;
                $display("FAIL bp_occupancy c=%0d: occ=%0d pend=%0d rd_en=%b empty=%b expected occ<=2, no rd_en at pend 2 or empty",
                         c, dut.u_skid.occ_q, pend, bus.rd_en, bus.rd_empty);
            end
            if (prev_stall) begin
                checks++;
                if (!bus.m_valid || (bus.m_data !== prev_data)) begin
                    errors++;
                    $display("FAIL bp_hold c=%0d: valid=%b data=%h expected 1/%h", c, bus.m_valid,
                             bus.m_data, prev_data);
                end
            end
            if (bus.m_valid && bus.m_ready) begin
                checks++;
                if (bus.m_data !== DW'(32'h30 + got)) begin
                    errors++;
                    $display("FAIL bp_data beat%0d: got %h expected %h", got, bus.m_data,
                             DW'(32'h30 + got));
                end
                got++;
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
        checks++;
        if (got != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d beats expected 6", got);
        end
        @(negedge rd_clk); #1;
        checks++;
        if ((bus.m_valid !== 1'b0) || (words !== CW'(6))) begin
            errors++;
            $display("FAIL bp_tail: m_valid=%b words_out=%0d expected 0/6", bus.m_valid, words);
        end
    endtask

    task automatic test_burst();
        int got = 0;
        logic exp_last;
        do_reset(8, 32'hA0);
        en = 1'b1;
        bus.m_ready = 1'b1;
        for (int c = 0; c < 20 && got < 8; c++) begin
            @(negedge rd_clk); #1;
            if (bus.m_valid) begin
                exp_last = ((got + 1) % 4 == 0);
                checks++;
                if (bus.m_data !== DW'(32'hA0 + got)) begin
                    errors++;
                    $display("FAIL burst_data beat%0d: got %h expected %h", got + 1, bus.m_data,
                             DW'(32'hA0 + got));
                end
                checks++;
                if ((bus.m_last !== exp_last) || (bus0.m_last !== 1'b0)) begin
                    errors++;
                    $display("FAIL burst_m_last beat%0d: got %b/%b expected %b/0", got + 1,
                             bus.m_last, bus0.m_last, exp_last);
                end
                got++;
            end
        end
        checks++;
        if (got != 8) begin
            errors++;
            $display("FAIL burst_count: got %0d beats expected 8", got);
        end
        en = 1'b0;
        for (int c = 0; c < 10 && busy; c++) @(negedge rd_clk);
        #1;
        checks++;
        if ((busy !== 1'b0) || (busy0 !== 1'b0) || (dut.beat_cnt_q !== '0) || (words !== CW'(8))) begin
            errors++;
            $display("FAIL burst_idle: busy=%b/%b beat_cnt=%0d words_out=%0d expected 0/0/0/8",
                     busy, busy0, dut.beat_cnt_q, words);
        end
    endtask

    task automatic test_stall_stop();
        int pulses = 0;
        int got = 0;
        do_reset(5, 32'h50);
        en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge rd_clk); #1;
            if (bus.rd_en) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL stall_rd_en_pulses: got %0d expected 2", pulses);
        end
        checks++;
        if ({bus.rd_en, bus.m_valid} !== 2'b01 || bus.m_data !== 32'h50) begin
            errors++;
            $display("FAIL stall_head: rd_en/m_valid=%b data=%h expected 01/00000050",
                     {bus.rd_en, bus.m_valid}, bus.m_data);
        end
        en = 1'b0;
        @(negedge rd_clk); #1;
        checks++;
        if ((busy !== 1'b1) || (dut.state_q !== STOP) || (bus.rd_en !== 1'b0)) begin
            errors++;
            $display("FAIL stall_stop_state: busy=%b state=%0d rd_en=%b expected 1/%0d/0",
                     busy, dut.state_q, bus.rd_en, STOP);
        end
        bus.m_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (bus.m_valid) begin
                checks++;
                if (bus.m_data !== DW'(32'h50 + got)) begin
                    errors++;
                    $display("FAIL stall_drain_data beat%0d: got %h expected %h", got, bus.m_data,
                             DW'(32'h50 + got));
                end
                got++;
            end
            @(negedge rd_clk);
        end
        #1;
        checks++;
        if ((got != 2) || (busy !== 1'b0) || (words !== CW'(2)) || (5'(wr_cnt - rd_ptr) !== 5'd3)) begin
            errors++;
            $display("FAIL stall_drain_end: beats=%0d busy=%b words_out=%0d left=%0d expected 2/0/2/3",
                     got, busy, words, 5'(wr_cnt - rd_ptr));
        end
    endtask

    task automatic test_unexpected();
        do_reset(0, 32'h0);
        en = 1'b1;
        bus.m_ready = 1'b1;
        @(negedge rd_clk);
        inject = 1'b1;
        @(negedge rd_clk);
        inject = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL unexp_before: err_unexp got %b expected 0", err);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge rd_clk); #1;
            checks++;
            if ({err, err0, bus.m_valid, bus.rd_en} !== 4'b1100 || words !== '0) begin
                errors++;
                $display("FAIL unexp_sticky c=%0d: err/err0/m_valid/rd_en=%b words_out=%0d expected 1100/0",
                         c, {err, err0, bus.m_valid, bus.rd_en}, words);
            end
        end
        do_reset(0, 32'h0);
        #1;
        checks++;
        if ({err, err0} !== 2'b00) begin
            errors++;
            $display("FAIL unexp_reset_clear: got %b expected 00", {err, err0});
        end
    endtask

    initial begin
        bus.m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_burst();
        test_stall_stop();
        test_unexpected();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
